// File: rtl/noc_route_demux.sv
// Tree-fabric routing node: one buffered input channel is steered to NUM_OUT
// registered output channels by comparing the destination field with a programmable address/mask.
module noc_route_demux #(
    parameter int                DATA_W   = 9,
    parameter int                ADDR_MSB = 8,
    parameter int                ADDR_W   = 4,
    parameter int                NUM_OUT  = 2,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RST_ADDR = 4'b1010,
    parameter logic [ADDR_W-1:0] RST_MASK = 4'b1110,
    parameter logic              RST_LEAF = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_OUT-1:0]      out_valid,
    input  logic [NUM_OUT-1:0]      out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [ADDR_W-1:0]       cfg_mask,
    input  logic                    cfg_leaf,
    output logic [NUM_OUT*16-1:0]   pkt_cnt,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int SEL_W = $clog2(NUM_OUT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mask_q;
    logic              leaf_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              empty;
    logic [DATA_W-1:0] head;

    logic [ADDR_W-1:0] field;
    logic [ADDR_W-1:0] lead_mask;
    logic [SEL_W-1:0]  target;
    logic              route_err;
    int                ones;

    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign field    = head[ADDR_MSB -: ADDR_W];
    assign pop      = !empty && (!out_valid[target] || out_ready[target]);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        ones      = $countones(mask_q);
        lead_mask = ~({ADDR_W{1'b1}} >> ones);
        target    = SEL_W'(NUM_OUT - 1);
        route_err = 1'b0;
        if (leaf_q) begin
            if ((field & mask_q) == addr_q) target = '0;
        end else if ((ones + SEL_W > ADDR_W) || (mask_q != lead_mask) ||
                     ((field & mask_q) != addr_q)) begin
            route_err = 1'b1;
        end else begin
            // Select bits sit directly below the matched prefix.
            target = SEL_W'(field >> (ADDR_W - ones - SEL_W));
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked solely by count, so stale contents are never used.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q <= RST_ADDR;
            mask_q <= RST_MASK;
            leaf_q <= RST_LEAF;
            err    <= 1'b0;
        end else begin
            if (cfg_we) begin
                addr_q <= cfg_addr;
                mask_q <= cfg_mask;
                leaf_q <= cfg_leaf;
            end
            if (pop && route_err) err <= 1'b1;
            else if (err_clr)     err <= 1'b0;
        end
    end

    // Per-port holding stages and delivered-packet counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid <= '0;
            out_data  <= '0;
            pkt_cnt   <= '0;
        end else begin
            for (int p = 0; p < NUM_OUT; p++) begin
                if (out_valid[p] && out_ready[p])
                    pkt_cnt[p*16 +: 16] <= pkt_cnt[p*16 +: 16] + 16'd1;
                if (pop && (target == SEL_W'(p))) begin
                    out_valid[p]                <= 1'b1;
                    out_data[p*DATA_W +: DATA_W] <= head;
                end else if (out_ready[p]) begin
                    out_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_route_demux.sv
// Directed bench for noc_route_demux: a 2-port node (default parameters) and a 4-port branch node.
module tb_noc_route_demux;

    logic        CLK;
    logic        RESET;

    logic        in_valid, in_ready, cfg_we, cfg_leaf, err, err_clr;
    logic [8:0]  in_data;
    logic [1:0]  out_valid, out_ready;
    logic [17:0] out_data;
    logic [3:0]  cfg_addr, cfg_mask;
    logic [31:0] pkt_cnt;

    logic        in_valid4, in_ready4, cfg_we4, cfg_leaf4, err4, err_clr4;
    logic [8:0]  in_data4;
    logic [3:0]  out_valid4, out_ready4;
    logic [35:0] out_data4;
    logic [3:0]  cfg_addr4, cfg_mask4;
    logic [63:0] pkt_cnt4;

    int checks = 0;
    int errors = 0;

    noc_route_demux dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_leaf(cfg_leaf),
        .pkt_cnt(pkt_cnt), .err(err), .err_clr(err_clr)
    );

    noc_route_demux #(.NUM_OUT(4)) dut4 (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .cfg_we(cfg_we4), .cfg_addr(cfg_addr4), .cfg_mask(cfg_mask4), .cfg_leaf(cfg_leaf4),
        .pkt_cnt(pkt_cnt4), .err(err4), .err_clr(err_clr4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [8:0] pk4 [4];

    initial begin
        pk4 = '{9'h111, 9'h151, 9'h191, 9'h1D1};
        RESET = 1'b1;
        in_valid = 0; in_data = '0; out_ready = '0; cfg_we = 0; cfg_addr = '0;
        cfg_mask = '0; cfg_leaf = 0; err_clr = 0;
        in_valid4 = 0; in_data4 = '0; out_ready4 = '0; cfg_we4 = 0; cfg_addr4 = '0;
        cfg_mask4 = '0; cfg_leaf4 = 0; err_clr4 = 0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pkt_cnt", pkt_cnt, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        RESET = 1'b0;
        tick();

        // Default branch config: field 1010 -> port 0, field 1011 -> port 1.
        out_ready = 2'b11;
        in_valid = 1; in_data = 9'h143; tick();
        in_valid = 0;
        check("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("br_p0_valid", 32'(out_valid), 32'd1);
        check("br_p0_data", 32'(out_data[8:0]), 32'h143);
        check("br_p0_err", 32'(err), 32'd0);
        tick();
        check("br_p0_drain", 32'(out_valid), 32'd0);
        check("br_p0_cnt", 32'(pkt_cnt[15:0]), 32'd1);
        in_valid = 1; in_data = 9'h164; tick();
        in_valid = 0; tick();
        check("br_p1_valid", 32'(out_valid), 32'd2);
        check("br_p1_data", 32'(out_data[17:9]), 32'h164);
        check("br_p1_err", 32'(err), 32'd0);
        tick();
        check("br_p1_cnt", 32'(pkt_cnt[31:16]), 32'd1);

        // Leaf mode: addr 0110 mask 1111.
        cfg_we = 1; cfg_addr = 4'b0110; cfg_mask = 4'b1111; cfg_leaf = 1; tick();
        cfg_we = 0;
        in_valid = 1; in_data = 9'h0C1; tick();
        in_valid = 0; tick();
        check("leaf_local_valid", 32'(out_valid), 32'd1);
        check("leaf_local_data", 32'(out_data[8:0]), 32'h0C1);
        tick();
        in_valid = 1; in_data = 9'h0E2; tick();
        in_valid = 0; tick();
        check("leaf_up_valid", 32'(out_valid), 32'd2);
        check("leaf_up_data", 32'(out_data[17:9]), 32'h0E2);
        check("leaf_err", 32'(err), 32'd0);
        tick();

        // 4-way branch: mask 1000, addr 1000, back-to-back at full rate.
        cfg_we4 = 1; cfg_addr4 = 4'b1000; cfg_mask4 = 4'b1000; cfg_leaf4 = 0; tick();
        cfg_we4 = 0;
        out_ready4 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            in_valid4 = (i < 4);
            if (i < 4) in_data4 = pk4[i];
            tick();
            check("br4_valid", 32'(out_valid4), (i >= 1 && i <= 4) ? (32'd1 << (i - 1)) : 32'd0);
            if (i >= 1 && i <= 4) check("br4_data", 32'(out_data4[(i-1)*9 +: 9]), 32'(pk4[i-1]));
        end
        check("br4_err_clean", 32'(err4), 32'd0);
        in_valid4 = 1; in_data4 = 9'h011; tick();
        in_valid4 = 0; tick();
        check("br4_err_port", 32'(out_valid4), 32'h8);
        check("br4_err_data", 32'(out_data4[35:27]), 32'h011);
        check("br4_err_set", 32'(err4), 32'd1);
        tick();
        check("br4_err_sticky", 32'(err4), 32'd1);
        err_clr4 = 1; tick();
        err_clr4 = 0;
        check("br4_err_clr", 32'(err4), 32'd0);
        check("br4_cnt0", 32'(pkt_cnt4[15:0]), 32'd1);
        check("br4_cnt3", 32'(pkt_cnt4[63:48]), 32'd2);

        // Back-pressure with DEPTH=2 on the default branch config.
        cfg_we = 1; cfg_addr = 4'b1010; cfg_mask = 4'b1110; cfg_leaf = 0; tick();
        cfg_we = 0;
        out_ready = 2'b10;
        in_valid = 1; in_data = 9'h141; tick();
        in_data = 9'h142; tick();
        check("bp_held", 32'(out_data[8:0]), 32'h141);
        check("bp_ready_open", 32'(in_ready), 32'd1);
        in_data = 9'h143; tick();
        check("bp_full", 32'(in_ready), 32'd0);
        in_data = 9'h144; tick();
        check("bp_full2", 32'(in_ready), 32'd0);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stable", 32'(out_data[8:0]), 32'h141);
        out_ready = 2'b11; tick();
        check("bp_out2", 32'(out_data[8:0]), 32'h142);
        check("bp_reopen", 32'(in_ready), 32'd1);
        tick();
        check("bp_out3", 32'(out_data[8:0]), 32'h143);
        in_valid = 0; tick();
        check("bp_out4", 32'(out_data[8:0]), 32'h144);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_cnt0", 32'(pkt_cnt[15:0]), 32'd6);

        // Head-of-line blocking: port-1 packet stuck behind a port-0 head.
        out_ready = 2'b10;
        in_valid = 1; in_data = 9'h145; tick();
        in_data = 9'h146; tick();
        in_data = 9'h165; tick();
        in_valid = 0; tick();
        check("hol_blocked", 32'(out_valid), 32'd1);
        tick();
        check("hol_blocked2", 32'(out_valid), 32'd1);
        check("hol_p0_data", 32'(out_data[8:0]), 32'h145);
        out_ready = 2'b11; tick();
        check("hol_p0_next", 32'(out_valid), 32'd1);
        check("hol_p0_data2", 32'(out_data[8:0]), 32'h146);
        tick();
        check("hol_p1_free", 32'(out_valid), 32'd2);
        check("hol_p1_data", 32'(out_data[17:9]), 32'h165);
        tick();
        check("hol_cnt", pkt_cnt, {16'd3, 16'd8});

        // Reset with packets held and buffered.
        out_ready = 2'b00;
        in_valid = 1; in_data = 9'h147; tick();
        in_data = 9'h148; tick();
        in_valid = 0;
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("mid_valid_drop", 32'(out_valid), 32'd0);
        check("mid_cnt_zero", pkt_cnt, 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_cnt4_zero", pkt_cnt4[31:0], 32'd0);
        tick();
        RESET = 1'b0;
        out_ready = 2'b11;
        tick(); tick();
        check("mid_discarded", 32'(out_valid), 32'd0);

        // Counter wrap: 65536 port-1 deliveries at full rate.
        in_valid = 1; in_data = 9'h164;
        for (int i = 0; i < 65536; i++) tick();
        in_valid = 0;
        tick();
        check("wrap_ffff", 32'(pkt_cnt[31:16]), 32'hFFFF);
        tick();
        check("wrap_zero", 32'(pkt_cnt[31:16]), 32'd0);
        check("wrap_p0", 32'(pkt_cnt[15:0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_route_demux.md
# noc_route_demux

Parametrised routing node for the asynchronous-NoC tree fabric. It accepts packets on a single input channel, buffers them in a small FIFO, and decodes the destination field against a runtime-programmable node address/mask. Each packet is steered to one of `NUM_OUT` registered output channels. It generalises the fixed 1-to-2 tree decoder to N-way branching, adds buffering and back-pressure, and adds a config port, per-port packet counters and an error flag. It sits between RECV/SEND channel adapters at every branch and leaf of the tree.

## Interface
- `DATA_W`, 9, packet width.
- `ADDR_MSB`, 8, MSB index of destination field in packet.
- `ADDR_W`, 4, destination field width; field = `data[ADDR_MSB -: ADDR_W]`.
- `NUM_OUT`, 2, output ports; power of two, 2..8; `SEL_W = log2(NUM_OUT)`.
- `DEPTH`, 2, input FIFO entries, power of two, ≥2.
- `RST_ADDR`, 4'b1010, reset node address.
- `RST_MASK`, 4'b1110, reset node mask.
- `RST_LEAF`, 0, reset leaf mode.

Ports:
- `CLK`  in  1  clock; all state on posedge.
- `RESET`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input packet valid.
- `in_ready`  out  1  = FIFO not full.
- `in_data`  in  DATA_W  input packet.
- `out_valid`  out  NUM_OUT  per-port valid.
- `out_ready`  in  NUM_OUT  per-port ready.
- `out_data`  out  NUM_OUT*DATA_W  port p at `[p*DATA_W +: DATA_W]`.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`, `cfg_mask`  in  ADDR_W  new node address/mask.
- `cfg_leaf`  in  1  new leaf mode.
- `pkt_cnt`  out  NUM_OUT*16  per-port delivered-packet counters.
- `err`  out  1  sticky routing error.
- `err_clr`  in  1  clears `err`.

## Operation
- Input FIFO, `DEPTH` entries, registered. Write when `in_valid && in_ready`. `in_ready = (count != DEPTH)`; it does not depend on a same-cycle pop.
- Head routing uses the config registers current in the dispatch cycle. Let `a` = destination field and `L` = popcount(mask).
- Leaf mode: if `(a & mask) == addr`, target port 0 (local). Otherwise target port NUM_OUT-1 (uplink).
- Branch mode: target = `a[ADDR_W-1-L -: SEL_W]`.
  - If `L + SEL_W > ADDR_W`, the mask is not leading-ones contiguous, or `(a & mask) != addr`, the packet targets port NUM_OUT-1 and `err` is set.
- Per-port output register (`out_valid[p]`, `out_data[p]`) acts as a one-entry holding stage. It drains on `out_valid[p] && out_ready[p]`.
- Dispatch: the head pops into target port p when the FIFO is non-empty and (`!out_valid[p]` or `out_ready[p]`). Only one dispatch per cycle. The head blocks while its target port is full (head-of-line blocking is intended). Other ports still drain.
- Output data is never modified. `out_data[p]` holds stable while `out_valid[p] && !out_ready[p]`.
- `pkt_cnt[p]` increments by 1 on each port-p drain handshake and wraps 16'hFFFF→0.
- Config: `cfg_we` loads addr/mask/leaf at the posedge. It is legal at any time and takes effect from the next cycle's dispatch. Already-dispatched packets are unaffected.
- `err`: set on error dispatch, cleared by `err_clr`. Set wins over a simultaneous clear.

## Timing
- Reset (async assert, sync use after deassert):
  - FIFO empty, `in_ready=1`.
  - All `out_valid=0`, `out_data=0`.
  - `pkt_cnt=0`, `err=0`.
  - addr/mask/leaf = `RST_*`.
- Reset mid-operation discards all buffered and held packets without any output handshake.
- Latency: a packet accepted at edge t is dispatched at edge t+1 if the port is free. `out_valid` is high from cycle t+1 to t+2, i.e. 1 cycle from acceptance to output visibility, with data registered.
- Throughput: 1 packet/cycle sustained while the targeted ports' ready signals stay high.
- Full FIFO: `in_ready=0`. A write and a pop in the same cycle while not full keeps the count unchanged.
- Simultaneous `cfg_we` and dispatch: the dispatch uses the old config.

## Test plan
- Defaults, leaf=0, mask=1110, addr=1010, NUM_OUT=2: send field 1010 (bit5=0) → port 0; send field 1011 → port 1. `err=0` for both. Each `pkt_cnt` = 1 after drain.
- Leaf mode via cfg (addr=0110, mask=1111, leaf=1): field 0110 → port 0; field 0111 → port 1; `err` stays 0.
- NUM_OUT=4, mask=1000, addr=1000, branch: fields 1000/1010/1100/1110 → ports 0/1/2/3 in order, 1 per cycle with all ready high. Field 0xxx → port 3 with `err=1`. Then `err_clr` → 0.
- Back-pressure, DEPTH=2: hold `out_ready[0]=0` and send 4 port-0 packets. Expect 1 held in the output register, 2 in the FIFO, then `in_ready=0`. Release ready → packets emerge in order, with `out_data` stable while stalled.
- HOL: port 0 stalled, head targets port 0, next packet targets port 1 → the port-1 packet waits until port 0 drains.
- Assert `RESET` with packets in flight → all `out_valid` drop immediately and counters read 0. Also check counter wrap: preload via 65536 port-1 drains → `pkt_cnt[1]=0`.
